// File: rtl/uart_pkg.sv
// Shared constants for the serial console I/O port: register map, status bit
// positions and TX FSM state encoding.
package uart_pkg;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int ST_RXA  = 0;
    localparam int ST_TXS  = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_FERR = 3;
    localparam int ST_TXOV = 4;
    localparam int ST_TXB  = 5;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    function automatic logic [7:0] pack_status(
        input logic rxa, input logic txs, input logic ovr,
        input logic ferr, input logic txov, input logic txb);
        logic [7:0] s;
        s          = 8'h00;
        s[ST_RXA]  = rxa;
        s[ST_TXS]  = txs;
        s[ST_OVR]  = ovr;
        s[ST_FERR] = ferr;
        s[ST_TXOV] = txov;
        s[ST_TXB]  = txb;
        return s;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead byte FIFO with wrap-bit pointers; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_io_port.sv
// CPU-side DATA/STATUS port for the console UART: TX/RX byte FIFOs, one-frame
// TX pacing FSM and sticky error flags.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for a queued byte and an idle UART
// LAUNCH    | uart_transmit pulse, byte already latched in uart_tx_byte
// WAIT_BUSY | waiting for the UART to report it is transmitting
// WAIT_DONE | waiting for the current frame to finish
module uart_io_port
    import uart_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_sel,
    input  logic       io_wr,
    input  logic       io_rd,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    output logic       irq,
    output logic       uart_transmit,
    output logic [7:0] uart_tx_byte,
    input  logic       uart_is_transmitting,
    input  logic       uart_received,
    input  logic [7:0] uart_rx_byte,
    input  logic       uart_recv_error
);
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_tx_byte;
    logic [7:0] r_rdata;
    logic       r_irq;
    logic       r_ovr;
    logic       r_ferr;
    logic       r_txov;

    logic       w_data_wr;
    logic       w_data_rd;
    logic       w_status_rd;
    logic       w_tx_push;
    logic       w_tx_pop;
    logic       w_tx_empty;
    logic       w_tx_full;
    logic [7:0] w_tx_dout;
    logic       w_rx_push;
    logic       w_rx_pop;
    logic       w_rx_empty;
    logic       w_rx_full;
    logic [7:0] w_rx_dout;
    logic       w_ovr_set;
    logic       w_txov_set;
    logic       w_txb;
    logic [7:0] w_status;

    assign w_data_wr   = io_wr && (io_sel == REG_DATA);
    assign w_data_rd   = io_rd && (io_sel == REG_DATA);
    assign w_status_rd = io_rd && (io_sel == REG_STATUS);

    assign w_tx_pop   = (r_state == S_IDLE) && !w_tx_empty && !uart_is_transmitting;
    assign w_tx_push  = w_data_wr && (!w_tx_full || w_tx_pop);
    assign w_txov_set = w_data_wr && w_tx_full && !w_tx_pop;

    assign w_rx_pop   = w_data_rd && !w_rx_empty;
    assign w_rx_push  = uart_received && (!w_rx_full || w_rx_pop);
    assign w_ovr_set  = uart_received && w_rx_full && !w_rx_pop;

    assign w_txb    = !w_tx_empty || (r_state != S_IDLE);
    assign w_status = pack_status(!w_rx_empty, !w_tx_full, r_ovr, r_ferr, r_txov, w_txb);

    uart_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .din   (io_wdata),
        .dout  (w_tx_dout),
        .empty (w_tx_empty),
        .full  (w_tx_full)
    );

    uart_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .din   (uart_rx_byte),
        .dout  (w_rx_dout),
        .empty (w_rx_empty),
        .full  (w_rx_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_tx_pop) w_state_nxt = S_LAUNCH;
            S_LAUNCH:    w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (uart_is_transmitting) w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (!uart_is_transmitting) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tx_byte <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_tx_pop) r_tx_byte <= w_tx_dout;
        end
    end

    // An error event in the same cycle as a STATUS read wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
            r_txov <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_ovr  <= w_ovr_set       || (r_ovr  && !w_status_rd);
            r_ferr <= uart_recv_error || (r_ferr && !w_status_rd);
            r_txov <= w_txov_set      || (r_txov && !w_status_rd);
            r_irq  <= !w_rx_empty || r_ovr || r_ferr || r_txov;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 8'h00;
        end else if (io_rd) begin
            if (io_sel == REG_DATA) r_rdata <= w_rx_empty ? 8'h00 : w_rx_dout;
            else                    r_rdata <= w_status;
        end
    end

    assign io_rdata      = r_rdata;
    assign irq           = r_irq;
    assign uart_transmit = (r_state == S_LAUNCH);
    assign uart_tx_byte  = r_tx_byte;

endmodule

// File: tb/tb_uart_io_port.sv
// Directed bench for uart_io_port: register view, TX pacing, FIFO overflow,
// sticky flags and mid-frame reset.
module tb_uart_io_port;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       io_sel = 1'b0;
    logic       io_wr = 1'b0;
    logic       io_rd = 1'b0;
    logic [7:0] io_wdata = 8'h00;
    logic [7:0] io_rdata;
    logic       irq;
    logic       uart_transmit;
    logic [7:0] uart_tx_byte;
    logic       uart_is_transmitting = 1'b0;
    logic       uart_received = 1'b0;
    logic [7:0] uart_rx_byte = 8'h00;
    logic       uart_recv_error = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    uart_io_port #(.FIFO_AW(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .io_sel               (io_sel),
        .io_wr                (io_wr),
        .io_rd                (io_rd),
        .io_wdata             (io_wdata),
        .io_rdata             (io_rdata),
        .irq                  (irq),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .uart_received        (uart_received),
        .uart_rx_byte         (uart_rx_byte),
        .uart_recv_error      (uart_recv_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic sel, input logic [7:0] data);
        io_sel   = sel;
        io_wdata = data;
        io_wr    = 1'b1;
        tick();
        io_wr    = 1'b0;
    endtask

    task automatic io_read(input logic sel, output logic [7:0] data);
        io_sel = sel;
        io_rd  = 1'b1;
        tick();
        io_rd  = 1'b0;
        data   = io_rdata;
    endtask

    initial begin
        logic [7:0] rd;
        logic       seen_tx;

        // Reset state
        tick(); tick();
        check("rst_rdata",    io_rdata, 8'h00);
        check("rst_transmit", {7'd0, uart_transmit}, 8'h00);
        check("rst_tx_byte",  uart_tx_byte, 8'h00);
        rst = 1'b0;
        tick();
        check("rst_irq", {7'd0, irq}, 8'h00);
        io_read(1'b1, rd);
        check("rst_status", rd, 8'h02);
        check("rst_irq2", {7'd0, irq}, 8'h00);

        // Two-byte transmit with 50-cycle frames
        io_write(1'b0, 8'h41);
        check("launch_n1_transmit", {7'd0, uart_transmit}, 8'h00);
        io_write(1'b0, 8'h42);
        check("launch_n2_transmit", {7'd0, uart_transmit}, 8'h01);
        check("launch_byte0", uart_tx_byte, 8'h41);
        uart_is_transmitting = 1'b1;
        tick();
        check("launch_one_cycle", {7'd0, uart_transmit}, 8'h00);
        tick();
        io_read(1'b1, rd);
        check("tx_busy_status0", rd, 8'h22);
        repeat (47) tick();
        check("tx_byte_held", uart_tx_byte, 8'h41);
        uart_is_transmitting = 1'b0;
        tick();
        check("no_back_to_back", {7'd0, uart_transmit}, 8'h00);
        tick();
        check("launch2_transmit", {7'd0, uart_transmit}, 8'h01);
        check("launch_byte1", uart_tx_byte, 8'h42);
        uart_is_transmitting = 1'b1;
        tick(); tick();
        io_read(1'b1, rd);
        check("tx_busy_status1", rd, 8'h22);
        repeat (47) tick();
        uart_is_transmitting = 1'b0;
        tick(); tick();
        check("tx_no_third", {7'd0, uart_transmit}, 8'h00);
        io_read(1'b1, rd);
        check("tx_done_status", rd, 8'h02);

        // Writes to STATUS are ignored
        io_write(1'b1, 8'hFF);
        tick();
        io_read(1'b1, rd);
        check("status_wr_ignored", rd, 8'h02);

        // TX overflow with the UART held busy
        uart_is_transmitting = 1'b1;
        for (int i = 0; i < 17; i++) io_write(1'b0, 8'h60 + 8'(i));
        io_read(1'b1, rd);
        check("txov_status", rd, 8'h30);
        check("txov_irq", {7'd0, irq}, 8'h01);
        io_read(1'b1, rd);
        check("txov_cleared", rd, 8'h20);
        check("txov_irq_clear", {7'd0, irq}, 8'h00);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        uart_is_transmitting = 1'b0;
        tick();

        // RX overflow: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            uart_received = 1'b1;
            uart_rx_byte  = 8'(i);
            tick();
        end
        uart_received = 1'b0;
        tick();
        check("rx_irq", {7'd0, irq}, 8'h01);
        io_read(1'b1, rd);
        check("rx_ovr_status", rd, 8'h07);
        for (int i = 0; i < 16; i++) begin
            io_read(1'b0, rd);
            check("rx_data", rd, 8'(i));
        end
        io_read(1'b0, rd);
        check("rx_empty_read", rd, 8'h00);
        io_read(1'b1, rd);
        check("rx_drained_status", rd, 8'h02);

        // Framing error coincident with a STATUS read
        uart_recv_error = 1'b1;
        io_read(1'b1, rd);
        uart_recv_error = 1'b0;
        check("ferr_same_cycle", rd, 8'h02);
        io_read(1'b1, rd);
        check("ferr_next_read", rd, 8'h0A);
        io_read(1'b1, rd);
        check("ferr_cleared", rd, 8'h02);

        // Reset during WAIT_DONE with three bytes queued
        io_write(1'b0, 8'h71);
        io_write(1'b0, 8'h72);
        io_write(1'b0, 8'h73);
        io_write(1'b0, 8'h74);
        uart_is_transmitting = 1'b1;
        tick();
        io_read(1'b1, rd);
        check("pre_rst_status", rd, 8'h22);
        check("pre_rst_tx_byte", uart_tx_byte, 8'h71);
        rst = 1'b1;
        #1;
        check("mid_rst_rdata",    io_rdata, 8'h00);
        check("mid_rst_transmit", {7'd0, uart_transmit}, 8'h00);
        check("mid_rst_tx_byte",  uart_tx_byte, 8'h00);
        check("mid_rst_irq",      {7'd0, irq}, 8'h00);
        tick(); tick();
        rst = 1'b0;
        seen_tx = 1'b0;
        repeat (5) begin
            tick();
            if (uart_transmit) seen_tx = 1'b1;
        end
        uart_is_transmitting = 1'b0;
        repeat (10) begin
            tick();
            if (uart_transmit) seen_tx = 1'b1;
        end
        check("post_rst_no_launch", {7'd0, seen_tx}, 8'h00);
        io_read(1'b1, rd);
        check("post_rst_status", rd, 8'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
